// File: rtl/hh_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array with optional chain coupling.
// A single shared update datapath visits one neuron per cycle; per-neuron state lives in cell instances.

module hh_neuron_core #(
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 200,
    parameter int V_RESET    = 0,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int SYN_WEIGHT = 100,
    parameter int RC_W       = 2
) (
    input  logic [WIDTH-1:0] v_i,
    input  logic [WIDTH-1:0] stim_i,
    input  logic [RC_W-1:0]  rc_i,
    input  logic             syn_en_i,
    output logic [WIDTH-1:0] v_o,
    output logic [RC_W-1:0]  rc_o,
    output logic             fire_o
);
    // Two guard bits hold v + stim + syn without wrap before saturation.
    localparam int TW = WIDTH + 2;
    localparam logic [TW-1:0] SYN_T = TW'(SYN_WEIGHT);
    localparam logic [TW-1:0] THR_T = TW'(THRESHOLD);
    localparam logic [TW-1:0] MAX_T = {2'b00, {WIDTH{1'b1}}};

    logic [TW-1:0] t;
    logic [TW-1:0] t_sat;

    always_comb begin
        t      = {2'b00, v_i} - {2'b00, (v_i >> LEAK_SHIFT)} + {2'b00, stim_i}
                 + (syn_en_i ? SYN_T : '0);
        t_sat  = (t > MAX_T) ? MAX_T : t;
        v_o    = t_sat[WIDTH-1:0];
        rc_o   = '0;
        fire_o = 1'b0;
        if (rc_i != '0) begin
            v_o  = WIDTH'(V_RESET);
            rc_o = rc_i - RC_W'(1);
        end else if (t_sat >= THR_T) begin
            v_o    = WIDTH'(V_RESET);
            rc_o   = RC_W'(REFRAC);
            fire_o = 1'b1;
        end
    end
endmodule

module hh_neuron_cell #(
    parameter int WIDTH   = 8,
    parameter int RC_W    = 2,
    parameter int V_RESET = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             upd_en_i,
    input  logic [WIDTH-1:0] v_d_i,
    input  logic [RC_W-1:0]  rc_d_i,
    input  logic             spike_d_i,
    input  logic             stim_we_i,
    input  logic [WIDTH-1:0] stim_d_i,
    output logic [WIDTH-1:0] v_o,
    output logic [WIDTH-1:0] stim_o,
    output logic [RC_W-1:0]  rc_o,
    output logic             spike_o
);
    logic [WIDTH-1:0] v_q;
    logic [WIDTH-1:0] stim_q;
    logic [RC_W-1:0]  rc_q;
    logic             spike_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= WIDTH'(V_RESET);
            stim_q  <= '0;
            rc_q    <= '0;
            spike_q <= 1'b0;
        end else begin
            if (upd_en_i) begin
                v_q     <= v_d_i;
                rc_q    <= rc_d_i;
                spike_q <= spike_d_i;
            end
            if (stim_we_i)
                stim_q <= stim_d_i;
        end
    end

    assign v_o     = v_q;
    assign stim_o  = stim_q;
    assign rc_o    = rc_q;
    assign spike_o = spike_q;
endmodule

module hh_neuron_array #(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = 8,
    parameter int THRESHOLD  = 200,
    parameter int V_RESET    = 0,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int SYN_WEIGHT = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             stim_current,
    input  logic [$clog2(N_NEURONS)-1:0] stim_sel,
    input  logic                         stim_valid,
    input  logic                         mode,
    input  logic [$clog2(N_NEURONS)-1:0] state_sel,
    output logic [WIDTH-1:0]             state,
    output logic [N_NEURONS-1:0]         spike,
    output logic                         round_done,
    output logic [15:0]                  spike_count
);
    localparam int SEL_W = $clog2(N_NEURONS);
    localparam int RC_W  = (REFRAC < 1) ? 1 : $clog2(REFRAC + 1);

    logic [N_NEURONS-1:0][WIDTH-1:0] v_all;
    logic [N_NEURONS-1:0][WIDTH-1:0] stim_all;
    logic [N_NEURONS-1:0][RC_W-1:0]  rc_all;
    logic [N_NEURONS-1:0]            spike_all;

    logic [SEL_W-1:0] slot_q, slot_d;
    logic [WIDTH-1:0] state_q;
    logic             round_done_q;
    logic [15:0]      cnt_q, cnt_d;

    logic             syn_en;
    logic [WIDTH-1:0] v_upd;
    logic [RC_W-1:0]  rc_upd;
    logic             fire;

    // Chain input comes from the previous neuron's held spike; neuron 0 has none.
    always_comb begin
        syn_en = 1'b0;
        if (mode && slot_q != '0)
            syn_en = spike_all[slot_q - 1'b1];
    end

    hh_neuron_core #(
        .WIDTH(WIDTH), .THRESHOLD(THRESHOLD), .V_RESET(V_RESET),
        .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC), .SYN_WEIGHT(SYN_WEIGHT), .RC_W(RC_W)
    ) u_core (
        .v_i      (v_all[slot_q]),
        .stim_i   (stim_all[slot_q]),
        .rc_i     (rc_all[slot_q]),
        .syn_en_i (syn_en),
        .v_o      (v_upd),
        .rc_o     (rc_upd),
        .fire_o   (fire)
    );

    for (genvar k = 0; k < N_NEURONS; k++) begin : g_cell
        hh_neuron_cell #(.WIDTH(WIDTH), .RC_W(RC_W), .V_RESET(V_RESET)) u_cell (
            .clk       (clk),
            .rst       (rst),
            .upd_en_i  (slot_q == SEL_W'(k)),
            .v_d_i     (v_upd),
            .rc_d_i    (rc_upd),
            .spike_d_i (fire),
            .stim_we_i (stim_valid && (stim_sel == SEL_W'(k))),
            .stim_d_i  (stim_current),
            .v_o       (v_all[k]),
            .stim_o    (stim_all[k]),
            .rc_o      (rc_all[k]),
            .spike_o   (spike_all[k])
        );
    end

    always_comb begin
        slot_d = (slot_q == SEL_W'(N_NEURONS - 1)) ? '0 : slot_q + 1'b1;
        cnt_d  = cnt_q;
        if (fire && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q       <= '0;
            state_q      <= '0;
            round_done_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            slot_q       <= slot_d;
            state_q      <= v_all[state_sel];
            round_done_q <= (slot_q == SEL_W'(N_NEURONS - 1));
            cnt_q        <= cnt_d;
        end
    end

    assign state       = state_q;
    assign spike       = spike_all;
    assign round_done  = round_done_q;
    assign spike_count = cnt_q;
endmodule

// File: doc/hh_neuron_array.md
HH_NEURON_ARRAY -- requirements
Module: hh_neuron_array

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4: number of time-multiplexed neurons, 2..16.
REQ-002 SHALL have parameter WIDTH, default 8: membrane and stimulus width in bits, unsigned.
REQ-003 SHALL have parameter THRESHOLD, default 200: fire level.
REQ-004 SHALL have parameter V_RESET, default 0: post-spike membrane value.
REQ-005 SHALL have parameter LEAK_SHIFT, default 3: leak is v >> LEAK_SHIFT.
REQ-006 SHALL have parameter REFRAC, default 2: refractory length in own-update slots.
REQ-007 SHALL have parameter SYN_WEIGHT, default 100: chain synapse increment.
REQ-008 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-009 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-010 SHALL have port stim_current, input, WIDTH: stimulus value to store.
REQ-011 SHALL have port stim_sel, input, clog2(N_NEURONS): target neuron for stim write.
REQ-012 SHALL have port stim_valid, input, 1: write strobe for stim_current.
REQ-013 SHALL have port mode, input, 1: 0 = independent, 1 = chain coupling.
REQ-014 SHALL have port state_sel, input, clog2(N_NEURONS): neuron whose membrane drives state.
REQ-015 SHALL have port state, output, WIDTH: membrane of state_sel, registered.
REQ-016 SHALL have port spike, output, N_NEURONS: per-neuron spike flags.
REQ-017 SHALL have port round_done, output, 1: one-cycle pulse per completed update round.
REQ-018 SHALL have port spike_count, output, 16: total spikes since reset, saturating at 65535.

Function
REQ-019 SHALL keep per neuron k: membrane v[k] (WIDTH), stim[k] (WIDTH), refractory counter rc[k].
REQ-020 SHALL update exactly one neuron per cycle, slot pointer 0,1,..,N_NEURONS-1, wrapping to 0.
REQ-021 SHALL, on stim_valid, write stim_current into stim[stim_sel] at that edge; an update of the same neuron at that edge uses the old stim value.
REQ-022 SHALL, when rc[k] > 0 at its slot, set v[k] = V_RESET, decrement rc[k], add no stimulus.
REQ-023 SHALL otherwise compute in WIDTH+2 bits: t = v[k] - (v[k] >> LEAK_SHIFT) + stim[k] + syn, where syn = SYN_WEIGHT if mode=1, k>0 and spike[k-1]=1, else 0.
REQ-024 SHALL saturate t to 2^WIDTH-1 before compare and store.
REQ-025 SHALL, if saturated t >= THRESHOLD: set v[k] = V_RESET, rc[k] = REFRAC, spike[k] = 1; else v[k] = t, spike[k] = 0.
REQ-026 SHALL hold spike[k] from its firing slot until neuron k's next slot (one full round).
REQ-027 SHALL give neuron 0 no chain input; neuron N_NEURONS-1 drives no neuron (no wrap).
REQ-028 SHALL increment spike_count by 1 on each fire event, holding at 65535.
REQ-029 SHALL drive state = v[state_sel] with one-cycle latency.
REQ-030 SHALL assert round_done for the cycle following the slot N_NEURONS-1 update.
REQ-031 SHALL treat mode changes as taking effect at the next slot update.

Reset
REQ-032 SHALL, while rst=1, immediately force v=V_RESET, stim=0, rc=0, slot=0, spike=0, state=0, round_done=0, spike_count=0.
REQ-033 SHALL, after mid-operation reset deassertion, resume at slot 0 with all stimuli lost.

Verification
REQ-034 SHALL: reset, no stim writes, 40 cycles -> v all 0, spike=0, spike_count=0, round_done every 4th cycle.
REQ-035 SHALL: write stim[0]=50, mode=0 -> v[0] sequence 50,94,133,167,197, then fire on 6th update (t=223), v[0]=0, spike[0]=1 for 4 cycles, spike_count=1.
REQ-036 SHALL: after REQ-035 fire -> v[0] held 0 for 2 own-slots (rc 2,1), accumulation restarts at 50 on 3rd slot.
REQ-037 SHALL: mode=1, stim[0]=200, stim[1]=0 -> neuron 0 fires first slot; neuron 1 next cycle v[1]=100, no spike; mode=0 same -> v[1]=0.
REQ-038 SHALL: stim_valid with stim_sel equal to current slot -> that update uses old value, new value used one round later.
REQ-039 SHALL: rst pulse mid-round with v[2]=150 -> all outputs 0 asynchronously, first post-reset update is neuron 0.
